// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencer for addi/add/bne. Instructions take 4 cycles (ALU ops) or 3 cycles (bne), plus any fetch wait cycles. Fetch stalls while instr_valid is low.
// Define MULTICYCLE_CTRL_PERF_EN to build the retired-instruction counter; otherwise retired is tied to 0.
module multicycle_ctrl #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   output logic             instr_req,
   input  logic             instr_valid,
   input  logic [WIDTH-1:0] instr,
   input  logic             EQ,
   output logic [WIDTH-1:0] ir,
   output logic             RegWrite,
   output logic             ALUsrc,
   output logic [2:0]       ALUctrl,
   output logic             ImmSrc,
   output logic             pc_en,
   output logic             PCsrc,
   output logic             trap,
   output logic [WIDTH-1:0] retired
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_WB     = 3'd3,
      S_BR     = 3'd4,
      S_TRAP   = 3'd5
   } state_t;

   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] ir_q, ir_d;
   logic             is_addi, is_add, is_bne, rd_nz;

   assign is_addi = (ir_q[6:0] == OP_IMM) && (ir_q[14:12] == 3'b000);
   assign is_add  = (ir_q[6:0] == OP_REG) && (ir_q[14:12] == 3'b000) && (ir_q[31:25] == 7'b0000000);
   assign is_bne  = (ir_q[6:0] == OP_BRANCH) && (ir_q[14:12] == 3'b001);
   assign rd_nz   = (ir_q[11:7] != 5'd0);

   always_comb begin
      state_d = state_q;
      ir_d    = ir_q;
      case (state_q)
         S_FETCH: begin
            if (instr_valid) begin
               ir_d    = instr;
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            if (is_addi || is_add) state_d = S_EXEC;
            else if (is_bne)       state_d = S_BR;
            else                   state_d = S_TRAP;
         end
         S_EXEC:       state_d = S_WB;
         S_WB, S_BR:   state_d = S_FETCH;
         S_TRAP:       state_d = S_TRAP;
         default:      state_d = S_TRAP;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_FETCH;
         ir_q    <= '0;
      end else begin
         state_q <= state_d;
         ir_q    <= ir_d;
      end
   end

   // Moore decode of state and IR; only PCsrc looks at an input (EQ) directly.
   always_comb begin
      instr_req = 1'b0;
      RegWrite  = 1'b0;
      ALUsrc    = 1'b0;
      ALUctrl   = 3'b000;
      ImmSrc    = 1'b0;
      pc_en     = 1'b0;
      PCsrc     = 1'b0;
      trap      = 1'b0;
      case (state_q)
         S_FETCH: instr_req = 1'b1;
         S_EXEC:  ALUsrc    = is_addi;
         S_WB: begin
            ALUsrc   = is_addi;
            RegWrite = rd_nz;
            pc_en    = 1'b1;
         end
         S_BR: begin
            ALUctrl = 3'b001;
            ImmSrc  = 1'b1;
            pc_en   = 1'b1;
            PCsrc   = ~EQ;
         end
         S_TRAP:  trap = 1'b1;
         default: ;
      endcase
   end

   assign ir = ir_q;

`ifdef MULTICYCLE_CTRL_PERF_EN
   logic [WIDTH-1:0] retired_q, retired_d;

   assign retired_d = ((state_q == S_WB) || (state_q == S_BR)) ? retired_q + 1'b1 : retired_q;

   always_ff @(posedge clk) begin
      if (rst) retired_q <= '0;
      else     retired_q <= retired_d;
   end

   assign retired = retired_q;
`else
   assign retired = '0;
`endif

endmodule
